// File: rtl/dr_pkg.sv
// Shared dual-rail definitions: rail indices, code-word width and the bridge FSM states.
package dr_pkg;

  localparam int RAIL_NUM = 2;
  localparam int RAIL_F   = 0;
  localparam int RAIL_T   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    NULL = 2'd2
  } state_t;

  // One binary bit to its dual-rail code word; never produces both rails set.
  function automatic logic [RAIL_NUM-1:0] dr_encode(input logic bit_val);
    logic [RAIL_NUM-1:0] rails;
    rails         = '0;
    rails[RAIL_T] = bit_val;
    rails[RAIL_F] = ~bit_val;
    return rails;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/dr_tx_bridge.sv
// Clocked valid/ready producer to four-phase return-to-zero dual-rail async pipeline bridge.
module dr_tx_bridge
  import dr_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [WIDTH-1:0]                   data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic [WIDTH-1:0][RAIL_NUM-1:0]     data_o,
  input  logic                               ack_i,
  output logic                               err_o,
  output logic [15:0]                        tx_count_o
);

  logic                           ack_s;
  state_t                         state_reg;
  logic                           live_reg;
  logic [WIDTH-1:0][RAIL_NUM-1:0] data_reg;
  logic [WIDTH-1:0][RAIL_NUM-1:0] enc_word;
  logic                           err_reg;
  logic [15:0]                    tx_count_reg;
  logic                           accept;
  logic                           phase_clear;
  logic                           timeout_hit;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst),
    .d  (ack_i),
    .q  (ack_s)
  );

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_enc
    assign enc_word[gi] = dr_encode(data_i[gi]);
  end

  // live_reg keeps ready low while reset is held and lets it rise on the first clock after.
  assign ready_o     = (state_reg == IDLE) && live_reg && !ack_s;
  assign accept      = valid_i && ready_o;
  assign phase_clear = accept || ((state_reg == DATA) && ack_s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      live_reg     <= 1'b0;
      data_reg     <= '0;
      err_reg      <= 1'b0;
      tx_count_reg <= '0;
    end else begin
      live_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (ack_s) begin
            err_reg <= 1'b1;
          end else if (accept) begin
            data_reg  <= enc_word;
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (ack_s) begin
            data_reg  <= '0;
            state_reg <= NULL;
          end
        end
        NULL: begin
          if (!ack_s) begin
            tx_count_reg <= tx_count_reg + 16'd1;
            state_reg    <= IDLE;
          end
        end
        default: begin
          data_reg  <= '0;
          state_reg <= IDLE;
        end
      endcase
      if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  if (TIMEOUT > 0) begin : g_wdog
    localparam int PW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [PW-1:0] phase_reg;

    // Saturates at TIMEOUT so a stuck phase flags once and stays put.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        phase_reg <= '0;
      end else if (phase_clear) begin
        phase_reg <= '0;
      end else if ((state_reg != IDLE) && (phase_reg != PW'(TIMEOUT))) begin
        phase_reg <= phase_reg + 1'b1;
      end
    end

    assign timeout_hit = (state_reg != IDLE) && !phase_clear && (phase_reg == PW'(TIMEOUT - 1));
  end else begin : g_no_wdog
    logic unused_clear;
    assign unused_clear = phase_clear;
    assign timeout_hit  = 1'b0;
  end

  assign data_o     = data_reg;
  assign err_o      = err_reg;
  assign tx_count_o = tx_count_reg;

endmodule

// File: tb/tb_dr_tx_bridge.sv
// Self-checking bench for dr_tx_bridge: token table, scoreboard monitor and corner-case sequences.
module tb_dr_tx_bridge;
  import dr_pkg::*;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int TO = 16;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic [W-1:0]               data_i = '0;
  logic                       valid_i = 1'b0;
  logic                       ready_o;
  logic [W-1:0][RAIL_NUM-1:0] data_o;
  logic                       ack_i;
  logic                       ack_drv = 1'b0;
  logic                       err_o;
  logic [15:0]                tx_count_o;

  int resp_mode = 0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pair_viol = 0;
  int stab_viol = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  d;
    logic [15:0] tok;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  // Mode 1 is a zero-delay responder; otherwise ack comes from ack_drv.
  assign ack_i = (resp_mode == 1) ? (|data_o) : ack_drv;

  dr_tx_bridge #(
    .WIDTH(W),
    .SYNC_STAGES(S),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_i(data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o(data_o),
    .ack_i(ack_i),
    .err_o(err_o),
    .tx_count_o(tx_count_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s: got %0h", name, act);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      total++;
      bad++;
      $display("FAIL %s: ready_o stayed 0 for %0d cycles, want 1", name, n);
    end
  endtask

  task automatic wait_count(input logic [15:0] target, input string name);
    int n = 0;
    while (tx_count_o !== target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, tx_count_o, target);
  endtask

  task automatic send(input int k);
    wait_ready("send ready");
    data_i  = tbl[k].d;
    valid_i = 1'b1;
    exp_q.push_back(tbl[k].tok);
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = ~tbl[k].d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor: pops the expected token when a new word leaves the spacer.
  initial begin
    logic [15:0] cur;
    logic [15:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = data_o;
      if (!rst) begin
        prev = '0;
      end else begin
        for (int i = 0; i < W; i++) begin
          if (cur[2*i +: 2] == 2'b11) pair_viol++;
        end
        if (cur != 16'h0 && prev == 16'h0) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL token: got %0h want none (unexpected word)", cur);
          end else begin
            check("token", cur, exp_q.pop_front());
          end
        end else if (cur != 16'h0 && prev != 16'h0 && cur != prev) begin
          stab_viol++;
        end
        prev = cur;
      end
    end
  end

  // Delayed responder: acks 3 cycles after a token, releases 3 cycles after spacer.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (resp_mode == 2) begin
        if (!ack_drv && data_o != '0) begin
          cnt++;
          if (cnt == 3) begin
            ack_drv = 1'b1;
            cnt = 0;
          end
        end else if (ack_drv && data_o == '0) begin
          cnt++;
          if (cnt == 3) begin
            ack_drv = 1'b0;
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int last;
    tbl[0] = '{8'hA5, 16'h9966};
    tbl[1] = '{8'h00, 16'h5555};
    tbl[2] = '{8'hFF, 16'hAAAA};
    tbl[3] = '{8'h3C, 16'h5AA5};
    tbl[4] = '{8'h81, 16'h9556};

    // Reset state while rst is held
    #12;
    check("reset ready", ready_o, 1'b0);
    check("reset data", data_o, 16'h0);
    check("reset err", err_o, 1'b0);
    check("reset count", tx_count_o, 16'h0);
    @(negedge clk);
    check("reset ready held", ready_o, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready after release", ready_o, 1'b1);

    // Table of words through a 3-cycle responder
    @(negedge clk);
    resp_mode = 2;
    for (int k = 0; k < 5; k++) begin
      send(k);
      wait_count(16'(k + 1), "tx_count");
    end
    wait_ready("ready returns");
    check("ready returns", ready_o, 1'b1);
    check("err clean", err_o, 1'b0);

    // Back-to-back words with zero-delay responder
    resp_mode = 0;
    ack_drv   = 1'b0;
    do_reset();
    resp_mode = 1;
    valid_i   = 1'b1;
    last      = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ready("b2b ready");
      data_i = tbl[k].d;
      exp_q.push_back(tbl[k].tok);
      if (k > 0) begin
        check("b2b interval ok", ((cyc - last) <= 2*S + 4) && ((cyc - last) > 2*S), 1'b1);
      end
      last = cyc;
      @(negedge clk);
    end
    valid_i = 1'b0;
    wait_count(16'd5, "b2b count");

    // ack held high across reset release
    resp_mode = 0;
    ack_drv   = 1'b1;
    do_reset();
    repeat (5) @(negedge clk);
    check("ack-at-reset err", err_o, 1'b1);
    check("ack-at-reset ready", ready_o, 1'b0);
    valid_i = 1'b1;
    data_i  = tbl[0].d;
    repeat (4) @(negedge clk);
    check("ack-at-reset no accept", data_o, 16'h0);
    valid_i = 1'b0;
    ack_drv = 1'b0;
    wait_ready("ack-at-reset recover");
    check("ack-at-reset ready back", ready_o, 1'b1);
    resp_mode = 2;
    send(1);
    wait_count(16'd1, "ack-at-reset count");
    check("err sticky", err_o, 1'b1);

    // Watchdog with a responder that never acks
    resp_mode = 0;
    ack_drv   = 1'b0;
    do_reset();
    send(2);
    repeat (15) @(negedge clk);
    check("timeout err before", err_o, 1'b0);
    @(negedge clk);
    check("timeout err at 16", err_o, 1'b1);
    check("timeout token", data_o, tbl[2].tok);
    repeat (10) @(negedge clk);
    check("timeout token held", data_o, tbl[2].tok);

    // Reset in the middle of DATA
    do_reset();
    resp_mode = 2;
    send(3);
    wait_count(16'd1, "pre-reset count");
    resp_mode = 0;
    ack_drv   = 1'b0;
    send(0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid-DATA reset spacer", data_o, 16'h0);
    check("mid-DATA reset count", tx_count_o, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    resp_mode = 2;
    send(4);
    wait_count(16'd1, "post-reset count");

    // Counter wrap
    wait_ready("wrap ready");
    force dut.tx_count_reg = 16'hFFFF;
    @(negedge clk);
    release dut.tx_count_reg;
    send(1);
    wait_count(16'h0000, "count wrap");

    repeat (5) @(negedge clk);
    check("no both-rails pair", pair_viol, 0);
    check("token stable", stab_viol, 0);
    check("scoreboard drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
